// File: rtl/rps_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rps_frame_sequencer
// Purpose : Streams one raster frame through a green threshold, accumulates
//           green statistics and classifies the frame as rock/paper/scissors.
// Revision: 1.0 - initial release
// ============================================================================
module rps_frame_sequencer #(
    parameter int LENGTH            = 48,
    parameter int WIDTH             = 64,
    parameter int LEFT              = 16,
    parameter int LOWER_GREEN_ONE   = 0,
    parameter int UPPER_GREEN_ONE   = 100,
    parameter int LOWER_GREEN_TWO   = 120,
    parameter int UPPER_GREEN_TWO   = 255,
    parameter int LOWER_GREEN_THREE = 0,
    parameter int UPPER_GREEN_THREE = 100,
    parameter int ROCK_MAX_SUM      = 400,
    parameter int PAPER_MIN_SPAN    = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [23:0]                pix_data,
    output logic                       busy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_class,
    output logic [31:0]                res_sum,
    output logic [31:0]                res_sum_left,
    output logic [$clog2(WIDTH)-1:0]   res_left,
    output logic [$clog2(WIDTH)-1:0]   res_right
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(LENGTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        CLASSIFY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [31:0]     r_sum;
    logic [31:0]     r_sum_left;
    logic [CW-1:0]   r_left_t;
    logic [CW-1:0]   r_right_t;
    logic            r_found;

    logic            w_accept;
    logic            w_green;
    logic            w_col_last;
    logic            w_last_beat;
    logic [CW:0]     w_span;

    // Signed int comparison keeps zero / full-scale bounds free of constant-compare folding.
    function automatic logic in_range(input logic [7:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    assign w_green = in_range(pix_data[7:0],   LOWER_GREEN_ONE,   UPPER_GREEN_ONE)
                  && in_range(pix_data[15:8],  LOWER_GREEN_TWO,   UPPER_GREEN_TWO)
                  && in_range(pix_data[23:16], LOWER_GREEN_THREE, UPPER_GREEN_THREE);

    assign pix_ready   = (r_state == SCAN);
    assign busy        = (r_state != IDLE);
    assign w_accept    = pix_valid && pix_ready;
    assign w_col_last  = (r_col == CW'(WIDTH - 1));
    assign w_last_beat = w_col_last && (r_row == RW'(LENGTH - 1));
    assign w_span      = {1'b0, r_right_t} - {1'b0, r_left_t} + (CW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start) w_state_nxt = SCAN;
            SCAN:     if (w_accept && w_last_beat) w_state_nxt = CLASSIFY;
            CLASSIFY: w_state_nxt = DONE;
            DONE:     if (res_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_sum        <= '0;
            r_sum_left   <= '0;
            r_left_t     <= '0;
            r_right_t    <= '0;
            r_found      <= 1'b0;
            res_valid    <= 1'b0;
            res_class    <= '0;
            res_sum      <= '0;
            res_sum_left <= '0;
            res_left     <= '0;
            res_right    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row      <= '0;
                        r_col      <= '0;
                        r_sum      <= '0;
                        r_sum_left <= '0;
                        r_left_t   <= CW'(WIDTH - 1);
                        r_right_t  <= '0;
                        r_found    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_accept) begin
                        if (w_green) begin
                            r_sum   <= r_sum + 32'd1;
                            r_found <= 1'b1;
                            if (int'(r_col) < LEFT) r_sum_left <= r_sum_left + 32'd1;
                            if (r_col < r_left_t)   r_left_t   <= r_col;
                            if (r_col > r_right_t)  r_right_t  <= r_col;
                        end
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                CLASSIFY: begin
                    res_sum      <= r_sum;
                    res_sum_left <= r_sum_left;
                    res_valid    <= 1'b1;
                    if (!r_found) begin
                        res_class <= 2'd3;
                        res_left  <= '0;
                        res_right <= '0;
                    end else begin
                        res_left  <= r_left_t;
                        res_right <= r_right_t;
                        if (r_sum <= 32'(ROCK_MAX_SUM))
                            res_class <= 2'd0;
                        else if (w_span >= (CW+1)'(PAPER_MIN_SPAN))
                            res_class <= 2'd1;
                        else
                            res_class <= 2'd2;
                    end
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rps_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rps_frame_sequencer
// Purpose : Directed self-checking bench for rps_frame_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rps_frame_sequencer;

    localparam int W     = 64;
    localparam int L     = 48;
    localparam int FRAME = W * L;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_class;
    logic [31:0] res_sum;
    logic [31:0] res_sum_left;
    logic [5:0]  res_left;
    logic [5:0]  res_right;

    int n_checks = 0;
    int n_errors = 0;

    rps_frame_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_class    (res_class),
        .res_sum      (res_sum),
        .res_sum_left (res_sum_left),
        .res_left     (res_left),
        .res_right    (res_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int c0, input int c1, input int c2);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    // 0: all green, 1: all white, 2: 20x20 block at cols 10..29,
    // 3: 30x20 block at cols 40..59, 4: threshold-boundary column pattern
    function automatic logic [23:0] pix(input int pat, input int r, input int c);
        case (pat)
            0: return mk(0, 200, 0);
            1: return mk(255, 255, 255);
            2: return (r < 20 && c >= 10 && c <= 29) ? mk(0, 200, 0) : mk(255, 255, 255);
            3: return (r < 30 && c >= 40 && c <= 59) ? mk(0, 200, 0) : mk(255, 255, 255);
            default: begin
                case (c % 4)
                    0:       return mk(100, 120, 100);
                    1:       return mk(101, 120, 100);
                    2:       return mk(100, 255, 0);
                    default: return mk(100, 120, 101);
                endcase
            end
        endcase
    endfunction

    // Pulses start, then streams nbeats pixels; returns with the last beat driven.
    task automatic stream(input int pat, input bit gaps, input bit noise, input int nbeats);
        int idx = 0;
        int cyc = 0;
        @(negedge clk);
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = mk(0, 200, 0);
        check("ready_idle", 32'(pix_ready), 0);
        while (idx < nbeats && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("ready_first", 32'(pix_ready), 1);
            pix_valid = !(gaps && $urandom_range(0, 3) == 0);
            pix_data  = pix(pat, idx / W, idx % W);
            start     = noise && ($urandom_range(0, 40) == 0);
            if (pix_valid && pix_ready) idx++;
        end
        check("stream_done", idx, nbeats);
    endtask

    task automatic run_frame(input int pat, input bit gaps, input bit noise,
                             input int e_cls, input int e_sum, input int e_suml,
                             input int e_l, input int e_r);
        bit hold_ok = 1'b1;
        stream(pat, gaps, noise, FRAME);
        @(negedge clk);
        pix_valid = 1'b0;
        start     = 1'b0;
        check("lat_classify_valid", 32'(res_valid), 0);
        check("lat_classify_ready", 32'(pix_ready), 0);
        @(negedge clk);
        check("lat_valid", 32'(res_valid), 1);
        check("res_class", 32'(res_class), e_cls);
        check("res_sum", res_sum, e_sum);
        check("res_sum_left", res_sum_left, e_suml);
        check("res_left", 32'(res_left), e_l);
        check("res_right", 32'(res_right), e_r);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (noise) start = (i % 3 == 0);
            if (!res_valid || !busy || res_sum != 32'(e_sum)) hold_ok = 1'b0;
        end
        check("hold", 32'(hold_ok), 1);
        res_ready = 1'b1;
        start     = noise;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("accept_valid", 32'(res_valid), 0);
        check("accept_busy", 32'(busy), 0);
        check("retain_sum", res_sum, e_sum);
        @(negedge clk);
        check("no_restart", 32'(busy), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        res_ready = 1'b0;
        #1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(pix_ready), 0);
        check("rst_sum", res_sum, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1;
        @(negedge clk);
        check("idle_ignores_pix", 32'(busy), 0);
        pix_valid = 1'b0;

        run_frame(0, 1'b0, 1'b0, 1, 3072, 768, 0, 63);
        run_frame(1, 1'b0, 1'b0, 3, 0, 0, 0, 0);
        run_frame(2, 1'b0, 1'b0, 0, 400, 120, 10, 29);
        run_frame(3, 1'b0, 1'b0, 2, 600, 0, 40, 59);
        run_frame(4, 1'b0, 1'b0, 1, 1536, 384, 0, 62);
        run_frame(4, 1'b1, 1'b1, 1, 1536, 384, 0, 62);
        run_frame(2, 1'b1, 1'b1, 0, 400, 120, 10, 29);

        run_frame(0, 1'b0, 1'b0, 1, 3072, 768, 0, 63);
        stream(0, 1'b0, 1'b0, 1000);
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        start     = 1'b0;
        #1;
        check("midrst_valid", 32'(res_valid), 0);
        check("midrst_sum", res_sum, 0);
        check("midrst_class", 32'(res_class), 0);
        check("midrst_right", 32'(res_right), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(pix_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_result", 32'(res_valid), 0);
        run_frame(3, 1'b0, 1'b0, 2, 600, 0, 40, 59);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
